// File: rtl/debounce_bank.sv
// debounce_bank: per-channel input synchroniser with a tick-gated stability counter.
// Define DEBOUNCE_BANK_EDGE_EN to build the registered rise/fall/changed pulse outputs.
module debounce_bank #(
    parameter int CHANNELS    = 4,
    parameter int STABLE_CNT  = 16,
    parameter int PRESCALE    = 1,
    parameter bit RESET_LEVEL = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                changed
);

    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PRE_ONE  = PW'(1);
    localparam logic [CHANNELS-1:0] RST_VEC = {CHANNELS{RESET_LEVEL}};

    logic [CHANNELS-1:0]         sync1_r;
    logic [CHANNELS-1:0]         sync2_r;
    logic [CHANNELS-1:0]         out_r;
    logic [CHANNELS-1:0][CW-1:0] cnt_r;
    logic [CHANNELS-1:0][CW-1:0] cnt_nxt_s;
    logic [CHANNELS-1:0]         toggle_s;
    logic [PW-1:0]               pre_r;
    logic                        tick_s;

    // Shared sample tick: last count of the free-running prescaler.
    always_comb begin
        if (pre_r == PRE_LAST) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Per-channel stability count; an agreeing sample restarts the count, the
    // final disagreeing sample toggles the output instead of incrementing.
    always_comb begin
        cnt_nxt_s = cnt_r;
        toggle_s  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!tick_s) begin
                cnt_nxt_s[i] = cnt_r[i];
            end else if (sync2_r[i] == out_r[i]) begin
                cnt_nxt_s[i] = '0;
            end else if (cnt_r[i] == CNT_LAST) begin
                cnt_nxt_s[i] = '0;
                toggle_s[i]  = 1'b1;
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
    end

    // Synchroniser, prescaler, counters and debounced level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= RST_VEC;
            sync2_r <= RST_VEC;
            out_r   <= RST_VEC;
            cnt_r   <= '0;
            pre_r   <= '0;
        end else begin
            sync1_r <= in;
            sync2_r <= sync1_r;
            out_r   <= out_r ^ toggle_s;
            cnt_r   <= cnt_nxt_s;
            if (tick_s) begin
                pre_r <= '0;
            end else begin
                pre_r <= pre_r + PRE_ONE;
            end
        end
    end

    assign out = out_r;

`ifdef DEBOUNCE_BANK_EDGE_EN
    logic [CHANNELS-1:0] rise_r;
    logic [CHANNELS-1:0] fall_r;
    logic                changed_r;

    // Edge pulses registered on the same edge as the toggle so they align with the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_r    <= '0;
            fall_r    <= '0;
            changed_r <= 1'b0;
        end else begin
            rise_r    <= toggle_s & ~out_r;
            fall_r    <= toggle_s & out_r;
            changed_r <= |toggle_s;
        end
    end

    assign rise    = rise_r;
    assign fall    = fall_r;
    assign changed = changed_r;
`else
    assign rise    = '0;
    assign fall    = '0;
    assign changed = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: three configurations run side by side,
// a reference model queues the expected outputs each edge, plus latency checks.
module tb_debounce_bank;

`ifdef DEBOUNCE_BANK_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    // Instance 0: 16/1/level0, instance 1: 4/5/level0, instance 2: 16/1/level1.
    localparam int SCNT [3] = '{16, 4, 16};
    localparam int PRE  [3] = '{1, 5, 1};
    localparam logic [2:0] RLEV = 3'b100;

    typedef logic [2:0][12:0] snap_t;

    logic             clk;
    logic             rst_n;
    logic [2:0][3:0]  in_v;
    logic [2:0][3:0]  out_v;
    logic [2:0][3:0]  rise_v;
    logic [2:0][3:0]  fall_v;
    logic [2:0]       chg_v;

    int n_checks = 0;
    int n_pass   = 0;

    snap_t sbq[$];
    snap_t sb_e;
    snap_t m_snap;
    logic [3:0] m_s1 [3];
    logic [3:0] m_s2 [3];
    logic [3:0] m_o  [3];
    int         m_run [3][4];
    int         m_pc  [3];
    logic [3:0] m_tog;
    logic       m_tick;

    debounce_bank #(.CHANNELS(4), .STABLE_CNT(16), .PRESCALE(1), .RESET_LEVEL(1'b0)) dut_main (
        .clk(clk), .rst_n(rst_n), .in(in_v[0]), .out(out_v[0]),
        .rise(rise_v[0]), .fall(fall_v[0]), .changed(chg_v[0]));

    debounce_bank #(.CHANNELS(4), .STABLE_CNT(4), .PRESCALE(5), .RESET_LEVEL(1'b0)) dut_pre (
        .clk(clk), .rst_n(rst_n), .in(in_v[1]), .out(out_v[1]),
        .rise(rise_v[1]), .fall(fall_v[1]), .changed(chg_v[1]));

    debounce_bank #(.CHANNELS(4), .STABLE_CNT(16), .PRESCALE(1), .RESET_LEVEL(1'b1)) dut_high (
        .clk(clk), .rst_n(rst_n), .in(in_v[2]), .out(out_v[2]),
        .rise(rise_v[2]), .fall(fall_v[2]), .changed(chg_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Counts rising edges until out_v[k][ch] reaches lvl; 60 means the bound expired.
    task automatic wait_out(input int k, input int ch, input logic lvl, output int n);
        n = 0;
        while (n < 60) begin
            @(posedge clk);
            n++;
            #1;
            if (out_v[k][ch] === lvl) break;
        end
    endtask

    // Reference model: one expected snapshot per edge (or per reset) into the scoreboard.
    initial forever begin
        @(posedge clk or negedge rst_n);
        m_snap = '0;
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_s1[k] = {4{RLEV[k]}};
                m_s2[k] = {4{RLEV[k]}};
                m_o[k]  = {4{RLEV[k]}};
                m_pc[k] = 0;
                for (int c = 0; c < 4; c++) m_run[k][c] = 0;
                m_snap[k][12:9] = m_o[k];
            end
            sbq.delete();
        end else begin
            for (int k = 0; k < 3; k++) begin
                m_tick = (m_pc[k] == PRE[k] - 1);
                m_pc[k] = m_tick ? 0 : m_pc[k] + 1;
                m_tog = 4'b0000;
                for (int c = 0; c < 4; c++) begin
                    if (m_tick) begin
                        if (m_s2[k][c] != m_o[k][c]) begin
                            m_run[k][c]++;
                            if (m_run[k][c] == SCNT[k]) begin
                                m_tog[c] = 1'b1;
                                m_run[k][c] = 0;
                            end
                        end else begin
                            m_run[k][c] = 0;
                        end
                    end
                end
                m_s2[k] = m_s1[k];
                m_s1[k] = in_v[k];
                m_o[k]  = m_o[k] ^ m_tog;
                m_snap[k][12:9] = m_o[k];
                m_snap[k][8:5]  = m_tog & m_o[k] & {4{EDGE_EN}};
                m_snap[k][4:1]  = m_tog & ~m_o[k] & {4{EDGE_EN}};
                m_snap[k][0]    = (|m_tog) & EDGE_EN;
            end
        end
        sbq.push_back(m_snap);
    end

    // Scoreboard consumer: compare every DUT output on the falling edge.
    initial forever begin
        @(negedge clk);
        if (sbq.size() > 0) begin
            sb_e = sbq.pop_front();
            for (int k = 0; k < 3; k++) begin
                check_eq($sformatf("out%0d", k),  out_v[k],  sb_e[k][12:9]);
                check_eq($sformatf("rise%0d", k), rise_v[k], sb_e[k][8:5]);
                check_eq($sformatf("fall%0d", k), fall_v[k], sb_e[k][4:1]);
                check_eq($sformatf("chg%0d", k),  chg_v[k],  sb_e[k][0]);
            end
        end
    end

    initial begin
        int n;
        logic [3:0] rise_acc;
        int chg_n;
        rst_n   = 1'b0;
        in_v[0] = 4'h0;
        in_v[1] = 4'h0;
        in_v[2] = 4'hF;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check_eq("reset_out_level0", out_v[0], 4'h0);
        check_eq("reset_out_level1", out_v[2], 4'hF);

        // Step on channel 0, prescaled step on instance 1, falling step on instance 2.
        @(negedge clk);
        #1;
        in_v[0][0] = 1'b1;
        in_v[1][2] = 1'b1;
        in_v[2][0] = 1'b0;
        wait_out(0, 0, 1'b1, n);
        check_eq("latency_step", n, 18);
        repeat (30) @(negedge clk);
        #1;
        check_eq("prescaled_step", out_v[1], 4'h4);
        check_eq("level1_fall", out_v[2], 4'hE);

        // Burst 10 high, 1 low, then held; short glitch on the prescaled instance.
        @(negedge clk);
        #1;
        in_v[0][1] = 1'b1;
        in_v[1][0] = 1'b1;
        repeat (3) @(negedge clk);
        #1 in_v[1][0] = 1'b0;
        repeat (7) @(negedge clk);
        #1 in_v[0][1] = 1'b0;
        @(negedge clk);
        #1 in_v[0][1] = 1'b1;
        wait_out(0, 1, 1'b1, n);
        check_eq("latency_after_glitch", n, 18);
        check_eq("prescaled_glitch_ignored", out_v[1], 4'h4);

        // Simultaneous rise on channels 0 and 3.
        @(negedge clk);
        #1 in_v[0][0] = 1'b0;
        repeat (25) @(negedge clk);
        #1;
        in_v[0][0] = 1'b1;
        in_v[0][3] = 1'b1;
        rise_acc = 4'b0000;
        chg_n = 0;
        repeat (25) begin
            @(negedge clk);
            rise_acc = rise_acc | rise_v[0];
            chg_n += int'(chg_v[0]);
        end
        check_eq("dual_rise_bits", rise_acc, EDGE_EN ? 4'b1001 : 4'b0000);
        check_eq("dual_changed_cycles", chg_n, EDGE_EN ? 1 : 0);
        check_eq("dual_out", out_v[0], 4'hB);

        // Reset mid-count on channel 2, input held high through release.
        #1 in_v[0][2] = 1'b1;
        repeat (12) @(negedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("reset_mid_count", out_v[0], 4'h0);
        rst_n = 1'b1;
        wait_out(0, 2, 1'b1, n);
        check_eq("latency_after_reset", n, 18);
        repeat (5) @(negedge clk);
        #1;
        check_eq("final_out", out_v[0], 4'hF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent debounce channels, legal range 1..32.
REQ-002 Parameter STABLE_CNT, default 16: consecutive disagreeing sample ticks required before OUT changes, legal range 1..65535.
REQ-003 Parameter PRESCALE, default 1: clock cycles per sample tick, legal range 1..65535.
REQ-004 Parameter RESET_LEVEL, default 0: level (0 or 1) loaded into every channel's OUT and synchroniser at reset.
REQ-005 CLK  in  1  sole clock; all state updates on rising edge.
REQ-006 RST_N  in  1  reset, asynchronous, active-low.
REQ-007 IN  in  CHANNELS  raw asynchronous inputs, one bit per channel.
REQ-008 OUT  out  CHANNELS  debounced level, registered.
REQ-009 RISE  out  CHANNELS  one-cycle pulse per channel on OUT 0->1.
REQ-010 FALL  out  CHANNELS  one-cycle pulse per channel on OUT 1->0.
REQ-011 CHANGED  out  1  registered OR-reduction of RISE|FALL, same cycle as the pulses.

Function
REQ-012 Each IN bit SHALL pass through a 2-flop synchroniser (SYNC1, SYNC2) before any other use.
REQ-013 Prescaler SHALL be a free-running counter 0..PRESCALE-1 shared by all channels; TICK is high in cycles where the count equals PRESCALE-1; PRESCALE=1 gives TICK every cycle.
REQ-014 Each channel SHALL have a counter of width clog2(STABLE_CNT+1), updated only on TICK.
REQ-015 On TICK with SYNC2[i]==OUT[i]: counter[i] cleared to 0 (glitch rejection; any agreeing sample restarts the count).
REQ-016 On TICK with SYNC2[i]!=OUT[i] and counter[i]<STABLE_CNT-1: counter[i] increments by 1.
REQ-017 On TICK with SYNC2[i]!=OUT[i] and counter[i]==STABLE_CNT-1: OUT[i] toggles at that edge and counter[i] clears to 0; counter SHALL never exceed STABLE_CNT-1 or wrap.
REQ-018 Latency with PRESCALE=1: IN step first sampled at edge 1 SHALL appear on OUT after edge STABLE_CNT+2; no earlier, no later.
REQ-019 Latency with PRESCALE>1: OUT SHALL change on the STABLE_CNT-th consecutive TICK at which SYNC2 disagrees with OUT.
REQ-020 RISE[i]/FALL[i] SHALL be asserted for exactly the one cycle following the edge at which OUT[i] toggled, aligned with the new OUT value.
REQ-021 Channels SHALL be fully independent; simultaneous toggles on several channels SHALL each produce their own RISE/FALL bits and a single CHANGED cycle.
REQ-022 Between TICKs all counters and OUT SHALL hold.

Reset
REQ-023 RST_N low SHALL immediately force OUT, SYNC1, SYNC2 to RESET_LEVEL on all bits, all counters and the prescaler to 0, and RISE, FALL, CHANGED to 0.
REQ-024 Reset asserted mid-count SHALL discard partial counts; after release no RISE/FALL is produced unless IN differs from RESET_LEVEL for the full REQ-018 latency.
REQ-025 First TICK after reset release SHALL occur PRESCALE cycles after the first rising edge with RST_N high.

Configuration
REQ-026 Macro DEBOUNCE_BANK_EDGE_EN: when defined, RISE, FALL and CHANGED SHALL be implemented per REQ-020/021.
REQ-027 Without DEBOUNCE_BANK_EDGE_EN, the RISE, FALL and CHANGED ports SHALL remain present and be driven constant 0, with no edge registers synthesised; OUT behaviour is unchanged.

Verification
REQ-028 CHANNELS=4, STABLE_CNT=16, PRESCALE=1, RESET_LEVEL=0: IN[0] 0->1 held -> OUT[0]=1 after edge 18, RISE[0] and CHANGED high exactly one cycle, other channels silent.
REQ-029 Same config: IN[1] high for 10 cycles, low 1 cycle, high 20 cycles -> OUT[1] rises 18 edges after the second rising IN edge; no pulse from the first burst.
REQ-030 STABLE_CNT=4, PRESCALE=5: IN[2] step held -> OUT[2] changes on the 4th disagreeing TICK (TICK every 5 cycles); a 3-cycle glitch between TICKs not sampled -> no change.
REQ-031 IN[0] and IN[3] toggle same cycle -> RISE=4'b1001 for one cycle, CHANGED single one-cycle pulse.
REQ-032 RST_N asserted at count 10 of 16 with IN high, released with IN high -> OUT stays 0 until full 18-edge latency after release, then one RISE.
REQ-033 RESET_LEVEL=1, DEBOUNCE_BANK_EDGE_EN undefined: after reset OUT=4'b1111, IN held 1 -> OUT unchanged, RISE/FALL/CHANGED constantly 0 throughout.
